// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, load-use/divide stalls, branch flushes and stall/flush counters for a 5-stage pipeline
module hazard_controller #(
  parameter int DIV_LATENCY = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_num,
  input  logic [4:0]       id_rs2_num,
  input  logic             id_is_div,
  input  logic [4:0]       ex_rs1_num,
  input  logic [4:0]       ex_rs2_num,
  input  logic [4:0]       ex_rd_num,
  input  logic             ex_mem_read,
  input  logic             ex_div_start,
  input  logic [4:0]       mem_rd_num,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd_num,
  input  logic             wb_reg_write,
  input  logic             pc_src,
  output logic [1:0]       r1_solve,
  output logic [1:0]       r2_solve,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             div_busy,
  output logic             div_done,
  output logic [4:0]       div_rd_num,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] rd_n;
  logic lu, dh, stall;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic mw, input logic [4:0] mrd,
                                     input logic ww, input logic [4:0] wrd);
    return (mw && mrd != 5'd0 && mrd == rs) ? 2'b10 : (ww && wrd != 5'd0 && wrd == rs) ? 2'b01 : 2'b00;
  endfunction
  assign r1_solve = fwd(ex_rs1_num, mem_reg_write, mem_rd_num, wb_reg_write, wb_rd_num);
  assign r2_solve = fwd(ex_rs2_num, mem_reg_write, mem_rd_num, wb_reg_write, wb_rd_num);
  assign div_busy = state != IDLE;
  assign div_done = state == DONE;
  assign lu = ex_mem_read && ex_rd_num != 5'd0 && (ex_rd_num == id_rs1_num || ex_rd_num == id_rs2_num);
  assign dh = div_busy && (id_is_div || (div_rd_num != 5'd0 && (div_rd_num == id_rs1_num || div_rd_num == id_rs2_num)));
  // A taken branch makes the stalled decode instruction wrong-path, so it wins
  assign stall = (lu || dh) && !pc_src;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall || pc_src;
  assign flush_d = pc_src;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rd_n = div_rd_num;
    if (state != BUSY && ex_div_start) begin
      state_n = BUSY;
      cnt_n = 4'(DIV_LATENCY - 2);
      rd_n = ex_rd_num;
    end else if (state == DONE) state_n = IDLE;
    else if (state == BUSY) begin
      state_n = cnt == 4'd0 ? DONE : BUSY;
      cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      div_rd_num <= '0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div_rd_num <= rd_n;
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, stall_d};
      flush_count <= flush_count + {{(CNT_W-1){1'b0}}, pc_src};
    end
  end
endmodule
